// File: rtl/ctrl_frame_capturer_if.sv
// Bundles the per-port RX FIFO pop interface, the picosoc iomem read port and the config register port.
// The master drives FIFO data, bus requests and config writes; the slave (capturer) returns pops, data and status.
interface ctrl_frame_capturer_if #(
    parameter int PORTS = 4
);
    logic [8*PORTS-1:0] i_fifo_dout;
    logic [PORTS-1:0]   i_fifo_del;
    logic [PORTS-1:0]   i_fifo_empty;
    logic [PORTS-1:0]   o_fifo_rden;

    logic               iomem_valid;
    logic               iomem_ready;
    logic [3:0]         iomem_wstrb;
    logic [31:0]        iomem_addr;
    logic [31:0]        iomem_rdata;

    logic [3:0]         cfg_we;
    logic [31:0]        cfg_di;
    logic [31:0]        cfg_do;

    modport master (
        output i_fifo_dout, i_fifo_del, i_fifo_empty,
        output iomem_valid, iomem_wstrb, iomem_addr,
        output cfg_we, cfg_di,
        input  o_fifo_rden, iomem_ready, iomem_rdata, cfg_do
    );

    modport slave (
        input  i_fifo_dout, i_fifo_del, i_fifo_empty,
        input  iomem_valid, iomem_wstrb, iomem_addr,
        input  cfg_we, cfg_di,
        output o_fifo_rden, iomem_ready, iomem_rdata, cfg_do
    );
endinterface

// File: rtl/ctrl_frame_capturer.sv
// Captures one control frame at a time from round-robin RX FIFOs into a 16x32 RAM read by the CPU over iomem.
// Latency: 1 cycle arbitration, then 1 byte/cycle; iomem_ready/rdata 1 cycle after iomem_valid.
// Backpressure: FIFO pops stall while the selected port is empty; no new frame until the CPU acks. CTRL_FRAME_CAP_IRQ_EN adds o_irq.
module ctrl_frame_capturer #(
    parameter int PORTS     = 4,
    parameter int RAM_WORDS = 16
) (
    input  logic clk,
    input  logic arst_n,
    ctrl_frame_capturer_if.slave bus
`ifdef CTRL_FRAME_CAP_IRQ_EN
    ,
    output logic o_irq
`endif
);

    localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BYTES = 4 * RAM_WORDS;
    localparam int AW    = $clog2(RAM_WORDS);
    localparam int CW    = $clog2(BYTES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_DRAIN,
        S_DONE,
        S_HOLD
    } state_t;

    state_t             state, state_nxt;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      sel;
    logic [PW-1:0]      scan_pick;
    logic [PW-1:0]      scan_idx;
    logic               scan_found;

    logic [CW-1:0]      cnt;
    logic [CW-1:0]      len;
    logic               trunc;
    logic               rx_valid;
    logic               enable;
    logic [PORTS-1:0]   port_mask;
    logic [PORTS-1:0]   cap_port;
    logic               irq_en;

    logic [31:0]        ram [RAM_WORDS];

    logic               pop;
    logic               wr_en;
    logic               arb_go;
    logic               ack;
    logic               busy;
    logic               last_byte;
    logic [7:0]         sel_byte;
    logic               sel_del;
    logic               sel_empty;
    logic [PORTS-1:0]   rden;

    logic               io_ready;
    logic [31:0]        io_rdata;

    assign sel_byte  = bus.i_fifo_dout[{sel, 3'b000} +: 8];
    assign sel_del   = bus.i_fifo_del[sel];
    assign sel_empty = bus.i_fifo_empty[sel];
    assign ack       = bus.cfg_we[3] & bus.cfg_di[31];
    assign busy      = (state == S_RX) || (state == S_DRAIN);
    assign last_byte = (cnt == CW'(BYTES - 1));
    assign wr_en     = pop && (state == S_RX);

    // First eligible port at or after rr_ptr; mask only gates new arbitration
    always_comb begin
        scan_found = 1'b0;
        scan_pick  = '0;
        scan_idx   = '0;
        for (int i = 0; i < PORTS; i++) begin
            scan_idx = PW'((int'(rr_ptr) + i) % PORTS);
            if (!scan_found && port_mask[scan_idx] && !bus.i_fifo_empty[scan_idx]) begin
                scan_found = 1'b1;
                scan_pick  = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        arb_go    = 1'b0;
        rden      = '0;
        case (state)
            S_IDLE: begin
                if (enable && !rx_valid && scan_found) begin
                    arb_go    = 1'b1;
                    state_nxt = S_RX;
                end
            end
            S_RX: begin
                pop       = !sel_empty;
                rden[sel] = pop;
                if (pop) begin
                    if (sel_del) begin
                        state_nxt = S_DONE;
                    end else if (last_byte) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                pop       = !sel_empty;
                rden[sel] = pop;
                if (pop && sel_del) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_fifo_rden = rden;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sel       <= '0;
            cnt       <= '0;
            len       <= '0;
            trunc     <= 1'b0;
            rx_valid  <= 1'b0;
            cap_port  <= '0;
            rr_ptr    <= '0;
            enable    <= 1'b0;
            port_mask <= '0;
            for (int w = 0; w < RAM_WORDS; w++) begin
                ram[w] <= '0;
            end
        end else begin
            if (arb_go) begin
                sel   <= scan_pick;
                cnt   <= '0;
                trunc <= 1'b0;
            end
            // Byte n lands in word n>>2, most significant lane first
            if (wr_en) begin
                ram[cnt[AW+1:2]][{~cnt[1:0], 3'b000} +: 8] <= sel_byte;
                cnt <= cnt + 1'b1;
                if (!sel_del && last_byte) begin
                    trunc <= 1'b1;
                end
            end
            if (state == S_DONE) begin
                rx_valid <= 1'b1;
                len      <= cnt;
                cap_port <= PORTS'(1) << sel;
                rr_ptr   <= (sel == PW'(PORTS - 1)) ? '0 : sel + 1'b1;
            end
            if ((state == S_HOLD) && ack) begin
                rx_valid <= 1'b0;
            end
            if (bus.cfg_we[3]) begin
                enable    <= bus.cfg_di[28];
                port_mask <= bus.cfg_di[24 +: PORTS];
            end
        end
    end

`ifdef CTRL_FRAME_CAP_IRQ_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            irq_en <= 1'b0;
            o_irq  <= 1'b0;
        end else begin
            if (bus.cfg_we[1]) begin
                irq_en <= bus.cfg_di[12];
            end
            o_irq <= rx_valid & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // Single-cycle ready pulse; a held valid is acked every other cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            io_ready <= 1'b0;
            io_rdata <= '0;
        end else begin
            io_ready <= bus.iomem_valid & ~io_ready;
            io_rdata <= (bus.iomem_valid & ~io_ready) ? ram[bus.iomem_addr[AW+1:2]] : '0;
        end
    end

    assign bus.iomem_ready = io_ready;
    assign bus.iomem_rdata = io_rdata;

    always_comb begin
        bus.cfg_do               = '0;
        bus.cfg_do[31]           = rx_valid;
        bus.cfg_do[30]           = busy;
        bus.cfg_do[29]           = trunc;
        bus.cfg_do[28]           = enable;
        bus.cfg_do[24 +: PORTS]  = port_mask;
        bus.cfg_do[16 +: CW]     = len;
        bus.cfg_do[12]           = irq_en;
        bus.cfg_do[8 +: PORTS]   = cap_port;
    end

    logic unused_bits;
    assign unused_bits = ^{bus.iomem_wstrb, bus.iomem_addr, bus.cfg_di, bus.cfg_we};

endmodule
